// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, state encoding and modular reduction helper
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Single conditional subtraction; callers guarantee x < 2*m.
  function automatic logic [ALU_WIDTH:0] mod_reduce(input logic [ALU_WIDTH:0] x,
                                                    input logic [ALU_WIDTH:0] m);
    return (x >= m) ? x - m : x;
  endfunction

endpackage

// File: rtl/modmul_step.sv
// rtl/modmul_step.sv - one MSB-first interleaved step: R' = (2R + bit*a) mod p
module modmul_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  input  logic             bit_i,
  output logic [WIDTH-1:0] r_next
);

  localparam int EW = ALU_WIDTH + 1;

  logic [EW-1:0] p_ext;
  logic [EW-1:0] dbl;
  logic [EW-1:0] sum;

  // One extra bit of headroom: with r, a < p < 2^(WIDTH-1), 2r and dbl+a stay below 2p.
  always_comb begin
    p_ext  = EW'(p);
    dbl    = mod_reduce(EW'({r, 1'b0}), p_ext);
    sum    = bit_i ? mod_reduce(dbl + EW'(a), p_ext) : dbl;
    r_next = WIDTH'(sum);
  end

endmodule

// File: rtl/modmul_interleaved.sv
// rtl/modmul_interleaved.sv - sequential (a*b) mod p, one multiplier bit per clock
module modmul_interleaved
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             opselect,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] outR,
  output logic             err,
  output logic             rdy
);

  localparam int IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] outr_q, outr_d;
  logic [IW-1:0]    i_q, i_d;
  logic             bad_q, bad_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] r_step;
  logic             op_bad;

  modmul_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .a      (a_q),
    .p      (p_q),
    .bit_i  (b_q[i_q]),
    .r_next (r_step)
  );

  assign op_bad = (p < WIDTH'(2)) || p[WIDTH-1] || (a >= p);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r_d     = r_q;
    outr_d  = outr_q;
    i_d     = i_q;
    bad_d   = bad_q;
    err_d   = err_q;
    rdy_d   = rdy_q;

    case (state_q)
      RUN: begin
        r_d = r_step;
        i_d = i_q - IW'(1);
        if (i_q == '0) state_d = DONE;
      end
      DONE: begin
        outr_d  = bad_q ? '0 : r_q;
        err_d   = bad_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase

    // rdy_q is only high in DONE on the error path, so a rejected op can be
    // followed back-to-back by a held opselect.
    if (state_q != RUN && rdy_q && opselect) begin
      a_d     = a;
      b_d     = b;
      p_d     = p;
      r_d     = '0;
      i_d     = IW'(WIDTH - 1);
      bad_d   = op_bad;
      rdy_d   = op_bad;
      state_d = op_bad ? DONE : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      outr_q  <= '0;
      i_q     <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      outr_q  <= outr_d;
      i_q     <= i_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign outR = outr_q;
  assign err  = err_q;
  assign rdy  = rdy_q;

endmodule

// File: tb/tb_modmul_interleaved.sv
// tb/tb_modmul_interleaved.sv - directed vectors with queue scoreboard for modmul_interleaved
module tb_modmul_interleaved;

  localparam int W = 32;
  // Result becomes visible after edge W+1, i.e. on the (W+2)-th negedge after acceptance.
  localparam int DONE_NEG = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          opselect = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  p = '0;
  logic [W-1:0]  outR;
  logic          err;
  logic          rdy;

  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];

  modmul_interleaved dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opselect (opselect),
    .a        (a),
    .b        (b),
    .p        (p),
    .outR     (outR),
    .err      (err),
    .rdy      (rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!rdy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: waited %0d cycles, limit 100", n);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tp,
                        input logic [W-1:0] er, input logic ee);
    wait_idle();
    a = ta;
    b = tb_v;
    p = tp;
    opselect = 1'b1;
    exp_q.push_back({ee, er});
    @(posedge clk);
    #1;
    opselect = 1'b0;
  endtask

  // Monitor: spots an accepted request at the interface, then waits for its result.
  initial begin
    bit   tracking = 1'b0;
    bit   errp = 1'b0;
    int   cyc = 0;
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (tracking) begin
          tracking = 1'b0;
          void'(exp_q.pop_front());
        end
      end else begin
        if (tracking) begin
          cyc++;
          if (cyc == 1 && rdy) errp = 1'b1;
          if ((errp && cyc == 2) || (!errp && rdy && cyc > 1)) begin
            e = exp_q.pop_front();
            check("outR", outR, e[W-1:0]);
            check("err", W'(err), W'(e[W]));
            if (!errp) check("latency", W'(cyc), W'(DONE_NEG));
            tracking = 1'b0;
          end else if (cyc > 60) begin
            total++;
            bad++;
            $display("FAIL result_timeout: no result after %0d cycles, limit 60", cyc);
            void'(exp_q.pop_front());
            tracking = 1'b0;
          end
        end
        if (!tracking && opselect && rdy) begin
          tracking = 1'b1;
          errp = 1'b0;
          cyc = 0;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] inv13 [1:12];
    inv13 = '{1, 7, 9, 10, 8, 11, 2, 5, 3, 4, 6, 12};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", W'(rdy), 1);
    check("reset_outR", outR, 0);
    check("reset_err", W'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(3, 5, 7, 1, 1'b0);
    for (int k = 1; k <= 12; k++) run_op(W'(k), inv13[k], 13, 1, 1'b0);
    run_op(32'd2147483646, 32'd2147483646, 32'd2147483647, 1, 1'b0);
    run_op(123456, 0, 32'd2147483647, 0, 1'b0);
    run_op(10, 20, 97, 6, 1'b0);
    run_op(1000, 5000, 1009, 405, 1'b0);

    run_op(7, 3, 7, 0, 1'b1);
    run_op(0, 3, 0, 0, 1'b1);
    run_op(1, 3, 32'h8000_0001, 0, 1'b1);
    run_op(0, 3, 1, 0, 1'b1);
    run_op(3, 5, 7, 1, 1'b0);

    // Request during a run must be ignored and must not disturb the held result.
    run_op(10, 20, 97, 6, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("hold_outR", outR, 1);
    a = 5;
    b = 5;
    p = 11;
    opselect = 1'b1;
    @(posedge clk);
    #1;
    opselect = 1'b0;
    check("busy_rdy", W'(rdy), 0);

    run_op(3, 4, 7, 5, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", W'(rdy), 1);
    check("abort_outR", outR, 0);
    check("abort_err", W'(err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(4, 6, 7, 3, 1'b0);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
